// File: rtl/tmr_pkg.sv
// Shared types for the triplicated scrubbed memory: scrub FSM states and the
// bitwise 2-of-3 vote with corrected/uncorrectable classification.
package tmr_pkg;

  typedef enum logic [1:0] {
    SCRUB_IDLE      = 2'd0,
    SCRUB_READ      = 2'd1,
    SCRUB_CHECK     = 2'd2,
    SCRUB_WRITEBACK = 2'd3
  } scrub_state_t;

  // Words up to this width are voted; narrower words are zero-extended, and
  // zero padding never changes the equality or majority result.
  localparam int VOTE_MAX_WIDTH = 256;

  typedef logic [VOTE_MAX_WIDTH-1:0] vote_word_t;

  typedef struct packed {
    vote_word_t word;
    logic       corrected;
    logic       uncorrectable;
  } vote_result_t;

  function automatic vote_result_t vote_classify(input vote_word_t a,
                                                 input vote_word_t b,
                                                 input vote_word_t c);
    vote_result_t r;
    logic eq_ab;
    logic eq_ac;
    logic eq_bc;
    eq_ab = (a == b);
    eq_ac = (a == c);
    eq_bc = (b == c);
    r.word          = (a & b) | (a & c) | (b & c);
    // Two equal pairs imply all three equal, so "some pair but not all".
    r.corrected     = (eq_ab | eq_ac | eq_bc) & ~(eq_ab & eq_ac);
    r.uncorrectable = ~eq_ab & ~eq_ac & ~eq_bc;
    return r;
  endfunction

endpackage

// File: rtl/tmr_memory_copy.sv
// One copy of the storage array: a single write port and two registered,
// read-before-write read ports (A for the user path, B for the scrubber).
module tmr_memory_copy #(
  parameter int WIDTH_SIZE   = 64,
  parameter int ADDRESS_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [ADDRESS_SIZE-1:0] write_address,
  input  logic [WIDTH_SIZE-1:0]   write_data,
  input  logic                    read_a_enable,
  input  logic [ADDRESS_SIZE-1:0] read_a_address,
  output logic [WIDTH_SIZE-1:0]   read_a_data,
  input  logic                    read_b_enable,
  input  logic [ADDRESS_SIZE-1:0] read_b_address,
  output logic [WIDTH_SIZE-1:0]   read_b_data
);

  localparam int DEPTH = 2 ** ADDRESS_SIZE;

  // Contents start at zero and survive reset; only the read registers clear.
  logic [WIDTH_SIZE-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_a_data <= '0;
      read_b_data <= '0;
    end else begin
      if (read_a_enable) begin
        read_a_data <= mem[read_a_address];
      end
      if (read_b_enable) begin
        read_b_data <= mem[read_b_address];
      end
    end
  end

endmodule

// File: rtl/tmr_scrub_memory.sv
// Triplicated FIFO storage with voted registered reads, saturating error
// counters and a background scrubber that writes corrected words back.
module tmr_scrub_memory
  import tmr_pkg::*;
#(
  parameter int WIDTH_SIZE     = 64,
  parameter int ADDRESS_SIZE   = 10,
  parameter int SCRUB_INTERVAL = 256,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic                    write_full,
  input  logic [ADDRESS_SIZE-1:0] write_address,
  input  logic [WIDTH_SIZE-1:0]   write_data,
  input  logic                    read_enable,
  input  logic [ADDRESS_SIZE-1:0] read_address,
  output logic [WIDTH_SIZE-1:0]   read_data,
  output logic                    read_valid,
  output logic                    read_corrected,
  output logic                    read_uncorrectable,
  input  logic                    scrub_enable,
  output logic [COUNT_WIDTH-1:0]  corrected_count,
  output logic [COUNT_WIDTH-1:0]  uncorrectable_count,
  input  logic                    inject_enable,
  input  logic [1:0]              inject_copy,
  input  logic [WIDTH_SIZE-1:0]   inject_mask,
  output logic [1:0]              scrub_state,
  output logic [ADDRESS_SIZE-1:0] scrub_address
);

  localparam int IW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

  scrub_state_t            state, state_next;
  logic [IW-1:0]           interval_count, interval_next;
  logic [ADDRESS_SIZE-1:0] scrub_address_next;
  logic                    stale, stale_next;
  logic                    scrub_read, scrub_write, scrub_corr, scrub_uncorr;

  logic                    user_write, user_hit, mem_write;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WIDTH_SIZE-1:0]   wr_data [3];
  logic [WIDTH_SIZE-1:0]   rd_a [3];
  logic [WIDTH_SIZE-1:0]   rd_b [3];
  logic [WIDTH_SIZE-1:0]   scrub_word;
  vote_result_t            vote_a, vote_b;
  logic                    unused_vote;

  assign user_write  = write_enable & ~write_full;
  assign user_hit    = user_write & (write_address == scrub_address);
  // A user write always owns the shared write port; the scrubber waits.
  assign mem_write   = user_write | scrub_write;
  assign mem_address = user_write ? write_address : scrub_address;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      wr_data[k] = scrub_word;
      if (user_write) begin
        wr_data[k] = write_data;
        if (inject_enable && (inject_copy == 2'(k))) begin
          wr_data[k] = write_data ^ inject_mask;
        end
      end
    end
  end

  tmr_memory_copy #(.WIDTH_SIZE(WIDTH_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) u_copy0 (
    .clk(clk), .reset(reset), .write_enable(mem_write), .write_address(mem_address),
    .write_data(wr_data[0]), .read_a_enable(read_enable), .read_a_address(read_address),
    .read_a_data(rd_a[0]), .read_b_enable(scrub_read), .read_b_address(scrub_address),
    .read_b_data(rd_b[0]));

  tmr_memory_copy #(.WIDTH_SIZE(WIDTH_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) u_copy1 (
    .clk(clk), .reset(reset), .write_enable(mem_write), .write_address(mem_address),
    .write_data(wr_data[1]), .read_a_enable(read_enable), .read_a_address(read_address),
    .read_a_data(rd_a[1]), .read_b_enable(scrub_read), .read_b_address(scrub_address),
    .read_b_data(rd_b[1]));

  tmr_memory_copy #(.WIDTH_SIZE(WIDTH_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) u_copy2 (
    .clk(clk), .reset(reset), .write_enable(mem_write), .write_address(mem_address),
    .write_data(wr_data[2]), .read_a_enable(read_enable), .read_a_address(read_address),
    .read_a_data(rd_a[2]), .read_b_enable(scrub_read), .read_b_address(scrub_address),
    .read_b_data(rd_b[2]));

  assign vote_a = vote_classify(vote_word_t'(rd_a[0]), vote_word_t'(rd_a[1]), vote_word_t'(rd_a[2]));
  assign vote_b = vote_classify(vote_word_t'(rd_b[0]), vote_word_t'(rd_b[1]), vote_word_t'(rd_b[2]));
  assign unused_vote = ^{vote_a, vote_b};

  assign read_data          = vote_a.word[WIDTH_SIZE-1:0];
  assign read_corrected     = read_valid & vote_a.corrected;
  assign read_uncorrectable = read_valid & vote_a.uncorrectable;
  // Port B holds its data after READ, so the vote stays valid in WRITEBACK.
  assign scrub_word         = vote_b.word[WIDTH_SIZE-1:0];
  assign scrub_state        = state;

  always_comb begin
    state_next         = state;
    interval_next      = interval_count;
    scrub_address_next = scrub_address;
    stale_next         = stale;
    scrub_read         = 1'b0;
    scrub_write        = 1'b0;
    scrub_corr         = 1'b0;
    scrub_uncorr       = 1'b0;
    case (state)
      SCRUB_IDLE: begin
        stale_next = 1'b0;
        if (scrub_enable) begin
          if (interval_count == IW'(SCRUB_INTERVAL - 1)) begin
            interval_next = '0;
            state_next    = SCRUB_READ;
          end else begin
            interval_next = interval_count + IW'(1);
          end
        end
      end
      SCRUB_READ: begin
        scrub_read = 1'b1;
        stale_next = stale | user_hit;
        state_next = SCRUB_CHECK;
      end
      SCRUB_CHECK: begin
        stale_next = stale | user_hit;
        if (vote_b.uncorrectable) begin
          scrub_uncorr       = 1'b1;
          scrub_address_next = scrub_address + ADDRESS_SIZE'(1);
          state_next         = SCRUB_IDLE;
        end else if (vote_b.corrected) begin
          scrub_corr = 1'b1;
          state_next = SCRUB_WRITEBACK;
        end else begin
          scrub_address_next = scrub_address + ADDRESS_SIZE'(1);
          state_next         = SCRUB_IDLE;
        end
      end
      SCRUB_WRITEBACK: begin
        stale_next = stale | user_hit;
        if (!user_write) begin
          // A user write to this address since READ makes the voted word stale.
          scrub_write        = ~stale;
          scrub_address_next = scrub_address + ADDRESS_SIZE'(1);
          state_next         = SCRUB_IDLE;
        end
      end
      default: state_next = SCRUB_IDLE;
    endcase
  end

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] count,
                                                     input logic [1:0] inc);
    logic [COUNT_WIDTH+1:0] sum;
    sum = (COUNT_WIDTH+2)'(count) + (COUNT_WIDTH+2)'(inc);
    return (sum[COUNT_WIDTH+1:COUNT_WIDTH] != 2'b00) ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= SCRUB_IDLE;
      interval_count      <= '0;
      scrub_address       <= '0;
      stale               <= 1'b0;
      read_valid          <= 1'b0;
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else begin
      state               <= state_next;
      interval_count      <= interval_next;
      scrub_address       <= scrub_address_next;
      stale               <= stale_next;
      read_valid          <= read_enable;
      corrected_count     <= sat_add(corrected_count, {1'b0, read_corrected} + {1'b0, scrub_corr});
      uncorrectable_count <= sat_add(uncorrectable_count,
                                     {1'b0, read_uncorrectable} + {1'b0, scrub_uncorr});
    end
  end

endmodule
